control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
Hardwired sequencer that generates, every clock, the full set of datapath control strobes. Today a bench hand-drives these strobes one T-step at a time. The block fetches each instruction, decodes IR[31:27], and steps through the per-class T-step micro-sequence. It sits beside the datapath, driving its control inputs and reading back IR and the CON flip-flop.

Parameters:
RESET_RUN, 1, value of Run after reset release (1 = begin fetching immediately).

Ports:
Clock  input  1  system clock, rising edge
clear  input  1  asynchronous, active-low reset
IR  input  32  instruction register contents from datapath
CON_FF  input  1  branch-condition flip-flop from datapath
Stop  input  1  request halt at next instruction boundary
opcode  output  5  ALU operation select
Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-select and register-file strobes
HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Outportin, CONin  output  1 each  register load enables
HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout  output  1 each  bus drivers
Read, Write, IncPC  output  1 each  memory read/write and PC-increment
Run  output  1  1 while executing, 0 in reset or halt

Behaviour:
- State register is asynchronously cleared by clear=0.
  - While clear=0: state=RST, every output 0 (opcode=00000), Run=0.
  - clear asserted mid-instruction aborts the instruction immediately.
- After clear releases: RST moves to F0 on the next edge; Run=RESET_RUN. With RESET_RUN=0 the block holds in RST.
- Outputs are Moore-decoded from state and current IR. At most one bus driver is active per state.
- Fetch (all instructions):
  - F0: PCout, MARin, IncPC, Zin.
  - F1: Zlowout, PCin, Read, MDRin.
  - F2: MDRout, IRin. IR is valid from T3 onward.
- Execute, by IR[31:27]. After the last listed step the next state is F0, or HALT if Stop=1 at that edge.
  - ALU reg (00011–01010: add, sub, and, or, shr, shra, shl, ror/rol group):
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, Zin, opcode=IR[31:27].
    - T5: Zlowout, Gra, Rin.
  - ALU imm (01011 addi, 01100 andi, 01101 ori):
    - T3: Grb, Rout, Yin.
    - T4: Cout, Zin, opcode=IR[31:27].
    - T5: Zlowout, Gra, Rin.
  - mul/div (01110, 01111):
    - T3: Gra, Rout, Yin.
    - T4: Grb, Rout, Zin, opcode.
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin.
  - neg/not (10000, 10001):
    - T3: Grb, Rout, Zin, opcode.
    - T4: Zlowout, Gra, Rin.
  - ld (00000):
    - T3: Grb, BAout, Yin.
    - T4: Cout, Zin, opcode=00011.
    - T5: Zlowout, MARin.
    - T6: Read, MDRin.
    - T7: MDRout, Gra, Rin.
  - ldi (00001): T3–T4 as ld; T5: Zlowout, Gra, Rin.
  - st (00010): T3–T5 as ld; T6: Gra, Rout, MDRin (Read=0); T7: Write.
  - br (10010):
    - T3: Gra, Rout, CONin.
    - T4: PCout, Yin.
    - T5: Cout, Zin, opcode=00011.
    - T6: Zlowout, with PCin only if CON_FF=1.
  - Single-step T3 instructions:
    - jr (10011): Gra, Rout, PCin.
    - in (10101): Inportout, Gra, Rin.
    - out (10110): Gra, Rout, Outportin.
    - mfhi (10111): HIout, Gra, Rin.
    - mflo (11000): LOout, Gra, Rin.
  - nop (11001) and every undefined opcode: no T-steps; F2 goes directly to F0.
  - halt (11010): F2 goes to HALT.
- HALT: all strobes 0, Run=0. Exit only via clear.
- opcode output is 00000 in every state not listed above.
- Stop is sampled only at instruction boundaries and never truncates an instruction.
- Read and Write are never asserted in the same state.

Test Plan:
- clear=0 for 2 cycles, then released, IR=0x59080002 (addi r2,r1,2) -> Run=0 and all strobes 0 during reset; then F0, F1, F2, T3 (Grb,Rout,Yin), T4 (Cout,Zin,opcode=01011), T5 (Zlowout,Gra,Rin), back to F0. Six cycles per instruction.
- IR=0x00800000 (ld) -> 8 cycles; T4 opcode=00011; T6 Read=MDRin=1; T7 MDRout,Gra,Rin; Write never 1.
- IR=0x90800000 (br), once with CON_FF=1 and once with CON_FF=0 -> T6 Zlowout=1 in both runs; PCin=1 only when CON_FF=1.
- IR=0x70000000 (mul) -> T5 Zlowout+LOin, T6 Zhighout+HIin; IR=0xD0000000 (halt) -> HALT, Run=0 held for 20 cycles.
- Stop=1 raised during T4 of an add -> T5 completes, next state HALT; clear pulsed low during T4 of st -> all outputs 0 immediately, Write never asserted.
- IR=0xF8000000 (undefined opcode) -> F2 goes directly to F0; a bus-driver one-hot assertion holds throughout all runs.

Source files
------------

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetches, decodes IR[31:27] and steps through the
// per-class T-step micro-sequence, driving every datapath strobe as a Moore output.
module control_unit #(
   parameter bit RESET_RUN = 1'b1
) (
   input  logic        Clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   input  logic        Stop,
   output logic [4:0]  opcode,
   output logic        Gra, Grb, Grc, Rin, Rout, BAout,
   output logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin,
   output logic        Inportin, Outportin, CONin,
   output logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout,
   output logic        Read, Write, IncPC,
   output logic        Run
);

   typedef enum logic [3:0] {RST, F0, F1, F2, T3, T4, T5, T6, T7, HALT} state_t;
   typedef enum logic [3:0] {
      C_NOP, C_ALU, C_IMM, C_MULDIV, C_NEGNOT, C_LD, C_LDI, C_ST,
      C_BR, C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT
   } iclass_t;

   state_t     state, next_state, last_state;
   iclass_t    iclass;
   logic [4:0] op;

   assign op = IR[31:27];

   // Instruction class and the final T-step of that class; F2 means no execute steps.
   always_comb begin
      iclass = C_NOP;
      case (op)
         5'd0:                               iclass = C_LD;
         5'd1:                               iclass = C_LDI;
         5'd2:                               iclass = C_ST;
         5'd3, 5'd4, 5'd5, 5'd6,
         5'd7, 5'd8, 5'd9, 5'd10:            iclass = C_ALU;
         5'd11, 5'd12, 5'd13:                iclass = C_IMM;
         5'd14, 5'd15:                       iclass = C_MULDIV;
         5'd16, 5'd17:                       iclass = C_NEGNOT;
         5'd18:                              iclass = C_BR;
         5'd19:                              iclass = C_JR;
         5'd21:                              iclass = C_IN;
         5'd22:                              iclass = C_OUT;
         5'd23:                              iclass = C_MFHI;
         5'd24:                              iclass = C_MFLO;
         5'd26:                              iclass = C_HALT;
         default:                            iclass = C_NOP;
      endcase
      last_state = F2;
      case (iclass)
         C_ALU, C_IMM, C_LDI:                last_state = T5;
         C_MULDIV, C_BR:                     last_state = T6;
         C_NEGNOT:                           last_state = T4;
         C_LD, C_ST:                         last_state = T7;
         C_JR, C_IN, C_OUT, C_MFHI, C_MFLO:  last_state = T3;
         default:                            last_state = F2;
      endcase
   end

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) state <= RST;
      else        state <= next_state;
   end

   // Next state plus strobe decode; Stop only matters on the final step of an instruction.
   always_comb begin
      next_state = F0;
      opcode = 5'b00000;
      {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
      {HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Outportin, CONin} = '0;
      {HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout} = '0;
      {Read, Write, IncPC} = '0;
      Run = (state != RST) && (state != HALT);

      case (state)
         RST:  next_state = RESET_RUN ? F0 : RST;
         HALT: next_state = HALT;
         F0:   next_state = F1;
         F1:   next_state = F2;
         F2: begin
            if (iclass == C_HALT)        next_state = HALT;
            else if (last_state == F2)   next_state = Stop ? HALT : F0;
            else                         next_state = T3;
         end
         T3, T4, T5, T6, T7: begin
            if (state == last_state) next_state = Stop ? HALT : F0;
            else begin
               case (state)
                  T3:      next_state = T4;
                  T4:      next_state = T5;
                  T5:      next_state = T6;
                  T6:      next_state = T7;
                  default: next_state = F0;
               endcase
            end
         end
         default: next_state = F0;
      endcase

      case (state)
         F0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
         F1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         F2: begin MDRout = 1'b1; IRin = 1'b1; end
         T3: begin
            case (iclass)
               C_ALU, C_IMM:     begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               C_MULDIV:         begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               C_NEGNOT:         begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
               C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
               C_BR:             begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
               C_JR:             begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
               C_IN:             begin Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_OUT:            begin Gra = 1'b1; Rout = 1'b1; Outportin = 1'b1; end
               C_MFHI:           begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_MFLO:           begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               default: ;
            endcase
         end
         T4: begin
            case (iclass)
               C_ALU:            begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
               C_IMM:            begin Cout = 1'b1; Zin = 1'b1; opcode = op; end
               C_MULDIV:         begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
               C_NEGNOT:         begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_LD, C_LDI, C_ST: begin Cout = 1'b1; Zin = 1'b1; opcode = 5'b00011; end
               C_BR:             begin PCout = 1'b1; Yin = 1'b1; end
               default: ;
            endcase
         end
         T5: begin
            case (iclass)
               C_ALU, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_MULDIV:         begin Zlowout = 1'b1; LOin = 1'b1; end
               C_LD, C_ST:       begin Zlowout = 1'b1; MARin = 1'b1; end
               C_BR:             begin Cout = 1'b1; Zin = 1'b1; opcode = 5'b00011; end
               default: ;
            endcase
         end
         T6: begin
            case (iclass)
               C_MULDIV:         begin Zhighout = 1'b1; HIin = 1'b1; end
               C_LD:             begin Read = 1'b1; MDRin = 1'b1; end
               C_ST:             begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
               C_BR:             begin Zlowout = 1'b1; PCin = CON_FF; end
               default: ;
            endcase
         end
         T7: begin
            case (iclass)
               C_LD:             begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_ST:             Write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle strobe sequences compared against
// a table-driven instruction model, with directed and randomized instruction streams.
module tb_control_unit;

   logic        Clock = 1'b0;
   logic        clear = 1'b0;
   logic        CON_FF = 1'b0;
   logic        Stop = 1'b0;
   logic [31:0] IR = 32'h0;
   logic [4:0]  opcode;
   logic        Gra, Grb, Grc, Rin, Rout, BAout;
   logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Outportin, CONin;
   logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout;
   logic        Read, Write, IncPC, Run;

   int checks = 0;
   int failures = 0;

   control_unit #(.RESET_RUN(1'b1)) dut (
      .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
      .opcode(opcode),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin),
      .MARin(MARin), .MDRin(MDRin), .Inportin(Inportin), .Outportin(Outportin), .CONin(CONin),
      .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout),
      .MDRout(MDRout), .Inportout(Inportout), .Cout(Cout),
      .Read(Read), .Write(Write), .IncPC(IncPC), .Run(Run)
   );

   always #5 Clock = ~Clock;

   logic [28:0] ctl;
   assign ctl = {Gra, Grb, Grc, Rin, Rout, BAout, HIin, LOin, Yin, Zin, PCin, IRin, MARin,
                 MDRin, Inportin, Outportin, CONin, HIout, LOout, Zhighout, Zlowout, PCout,
                 MDRout, Inportout, Cout, Read, Write, IncPC, Run};

   localparam logic [28:0] GRA = 29'h1 << 28, GRB = 29'h1 << 27, GRC = 29'h1 << 26,
      RIN = 29'h1 << 25, ROUT = 29'h1 << 24, BAOUT = 29'h1 << 23, HIIN = 29'h1 << 22,
      LOIN = 29'h1 << 21, YIN = 29'h1 << 20, ZIN = 29'h1 << 19, PCIN = 29'h1 << 18,
      IRIN = 29'h1 << 17, MARIN = 29'h1 << 16, MDRIN = 29'h1 << 15, INPORTIN = 29'h1 << 14,
      OUTPORTIN = 29'h1 << 13, CONIN = 29'h1 << 12, HIOUT = 29'h1 << 11, LOOUT = 29'h1 << 10,
      ZHIGHOUT = 29'h1 << 9, ZLOWOUT = 29'h1 << 8, PCOUT = 29'h1 << 7, MDROUT = 29'h1 << 6,
      INPORTOUT = 29'h1 << 5, COUT = 29'h1 << 4, READ = 29'h1 << 3, WRITE = 29'h1 << 2,
      INCPC = 29'h1 << 1, RUN = 29'h1;

   logic [28:0] q_ctl[$];
   logic [4:0]  q_opc[$];

   function automatic void push(input logic [28:0] c, input logic [4:0] o);
      q_ctl.push_back(c | RUN);
      q_opc.push_back(o);
   endfunction

   // Expected per-cycle strobes for one whole instruction, fetch included.
   function automatic void build(input logic [4:0] op, input logic con);
      q_ctl.delete();
      q_opc.delete();
      push(PCOUT | MARIN | INCPC | ZIN, 5'd0);
      push(ZLOWOUT | PCIN | READ | MDRIN, 5'd0);
      push(MDROUT | IRIN, 5'd0);
      if (op <= 5'd2) begin
         push(GRB | BAOUT | YIN, 5'd0);
         push(COUT | ZIN, 5'd3);
         if (op == 5'd1) push(ZLOWOUT | GRA | RIN, 5'd0);
         else begin
            push(ZLOWOUT | MARIN, 5'd0);
            if (op == 5'd0) begin
               push(READ | MDRIN, 5'd0);
               push(MDROUT | GRA | RIN, 5'd0);
            end else begin
               push(GRA | ROUT | MDRIN, 5'd0);
               push(WRITE, 5'd0);
            end
         end
      end else if (op <= 5'd13) begin
         push(GRB | ROUT | YIN, 5'd0);
         push(((op <= 5'd10) ? (GRC | ROUT) : COUT) | ZIN, op);
         push(ZLOWOUT | GRA | RIN, 5'd0);
      end else if (op <= 5'd15) begin
         push(GRA | ROUT | YIN, 5'd0);
         push(GRB | ROUT | ZIN, op);
         push(ZLOWOUT | LOIN, 5'd0);
         push(ZHIGHOUT | HIIN, 5'd0);
      end else if (op <= 5'd17) begin
         push(GRB | ROUT | ZIN, op);
         push(ZLOWOUT | GRA | RIN, 5'd0);
      end else if (op == 5'd18) begin
         push(GRA | ROUT | CONIN, 5'd0);
         push(PCOUT | YIN, 5'd0);
         push(COUT | ZIN, 5'd3);
         push(ZLOWOUT | (con ? PCIN : 29'h0), 5'd0);
      end else if (op == 5'd19) push(GRA | ROUT | PCIN, 5'd0);
      else if (op == 5'd21)     push(INPORTOUT | GRA | RIN, 5'd0);
      else if (op == 5'd22)     push(GRA | ROUT | OUTPORTIN, 5'd0);
      else if (op == 5'd23)     push(HIOUT | GRA | RIN, 5'd0);
      else if (op == 5'd24)     push(LOOUT | GRA | RIN, 5'd0);
   endfunction

   // Bus drivers and memory strobes checked on every cycle the block is out of reset.
   always @(negedge Clock) begin
      if (clear) begin
         checks++;
         if ($countones({HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout,
                         Rout, BAout}) > 1 || (Read && Write)) begin
            failures++;
            $display("[TB] FAIL bus_onehot t=%0t: ctl=%h, required at most one driver and not Read&Write",
                     $time, ctl);
         end
      end
   end

   task automatic expect_zero(input string name);
      checks++;
      if (ctl !== 29'h0 || opcode !== 5'b00000) begin
         failures++;
         $display("[TB] FAIL %s: ctl=%h opcode=%b, required ctl=0 opcode=00000", name, ctl, opcode);
      end
   endtask

   task automatic hold_reset(input string name, input int n);
      clear = 1'b0;
      Stop = 1'b0;
      #1 expect_zero({name, "_assert"});
      repeat (n) begin
         @(negedge Clock);
         expect_zero({name, "_held"});
      end
      clear = 1'b1;
      #1 expect_zero({name, "_release"});
   endtask

   task automatic check_idle(input string name, input int n);
      repeat (n) begin
         @(negedge Clock);
         expect_zero(name);
      end
   endtask

   // One instruction from F0; IR changes only after F0 is sampled, as the datapath would.
   task automatic run_instr(input string name, input logic [31:0] ir, input logic con,
                            input int stop_step, input int abort_step);
      logic [28:0] e_ctl[$];
      logic [4:0]  e_opc[$];
      build(ir[31:27], con);
      e_ctl = q_ctl;
      e_opc = q_opc;
      for (int i = 0; i < e_ctl.size(); i++) begin
         @(negedge Clock);
         checks++;
         if (ctl !== e_ctl[i] || opcode !== e_opc[i]) begin
            failures++;
            $display("[TB] FAIL %s step%0d: ctl=%h opcode=%b, required ctl=%h opcode=%b",
                     name, i, ctl, opcode, e_ctl[i], e_opc[i]);
         end
         if (i == 0) begin
            IR = ir;
            CON_FF = con;
         end
         if (i == stop_step) Stop = 1'b1;
         if (i == abort_step) begin
            #1 clear = 1'b0;
            #1 expect_zero({name, "_abort"});
            return;
         end
      end
   endtask

   task automatic test_reset();
      hold_reset("reset", 2);
   endtask

   task automatic test_alu();
      run_instr("addi", 32'h5908_0002, 1'b0, -1, -1);
      run_instr("addi_again", 32'h5908_0002, 1'b0, -1, -1);
      run_instr("mul", 32'h7000_0000, 1'b0, -1, -1);
      run_instr("neg", 32'h8000_0000, 1'b0, -1, -1);
      run_instr("mfhi", 32'hB800_0000, 1'b0, -1, -1);
   endtask

   task automatic test_memory();
      run_instr("ld", 32'h0080_0000, 1'b0, -1, -1);
      run_instr("ldi", 32'h0880_0000, 1'b0, -1, -1);
      run_instr("st", 32'h1080_0000, 1'b0, -1, -1);
   endtask

   task automatic test_branch();
      run_instr("br_taken", 32'h9080_0000, 1'b1, -1, -1);
      run_instr("br_not_taken", 32'h9080_0000, 1'b0, -1, -1);
      run_instr("undefined", 32'hF800_0000, 1'b0, -1, -1);
      run_instr("nop", 32'hC800_0000, 1'b0, -1, -1);
   endtask

   task automatic test_halt();
      run_instr("halt", 32'hD000_0000, 1'b0, -1, -1);
      check_idle("halt_idle", 20);
      hold_reset("halt_recover", 2);
   endtask

   task automatic test_stop();
      run_instr("stop_add", 32'h1800_0000, 1'b0, 4, -1);
      check_idle("stop_halt", 3);
      hold_reset("stop_recover", 1);
   endtask

   task automatic test_abort();
      run_instr("st_abort", 32'h1000_0000, 1'b0, -1, 4);
      hold_reset("abort_recover", 2);
   endtask

   task automatic test_random();
      logic [4:0]  op;
      logic [31:0] ir;
      for (int n = 0; n < 60; n++) begin
         op = 5'($urandom_range(0, 31));
         ir = {op, 27'($urandom)};
         run_instr("random", ir, 1'($urandom), -1, -1);
         if (op == 5'd26) begin
            check_idle("random_halt", 2);
            hold_reset("random_recover", 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      run_instr("b2b_out", 32'hB000_0000, 1'b0, -1, -1);
      run_instr("b2b_in", 32'hA800_0000, 1'b0, -1, -1);
      run_instr("b2b_jr", 32'h9800_0000, 1'b0, -1, -1);
      run_instr("b2b_mflo", 32'hC000_0000, 1'b0, -1, -1);
   endtask

   initial begin
      test_reset();
      test_alu();
      test_memory();
      test_branch();
      test_halt();
      test_stop();
      test_abort();
      test_back_to_back();
      test_random();
      run_instr("final", 32'hC800_0000, 1'b0, -1, -1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
